// File: rtl/piezo_sched.sv
// Round-robin scheduler for up to four tone requesters in front of the single-tone piezo driver.
// Issues one start at a time and blocks further issues until the note and its silence gap end.
module piezo_sched #(
  parameter logic [24:0] NOTE_CYCLES = 25'h0800002,
  parameter logic [24:0] GAP_CYCLES  = 25'h0100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       clr,
  output logic       start,
  output logic [1:0] piezo_indx,
  output logic [3:0] grant,
  output logic       busy,
  output logic [3:0] pend
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StNote  = 2'd2,
    StGap   = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [24:0] timer_q, timer_d;
  logic [3:0]  pend_q, pend_d;
  logic [1:0]  rr_q, rr_d;
  logic [1:0]  sel_q, sel_d;
  logic        start_q, start_d;
  logic [3:0]  grant_q, grant_d;
  logic [1:0]  indx_q, indx_d;

  logic [7:0]  pend_dbl;
  logic [3:0]  pend_rot;
  logic [1:0]  offset;
  logic [1:0]  pick;

  // Rotate pending bits so the round-robin pointer lands on bit 0, then take the lowest set bit.
  always_comb begin
    pend_dbl = {pend_q, pend_q} >> rr_q;
    pend_rot = pend_dbl[3:0];
    if (pend_rot[0]) begin
      offset = 2'd0;
    end else if (pend_rot[1]) begin
      offset = 2'd1;
    end else if (pend_rot[2]) begin
      offset = 2'd2;
    end else begin
      offset = 2'd3;
    end
    pick = rr_q + offset;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      timer_q <= '0;
      pend_q  <= '0;
      rr_q    <= '0;
      sel_q   <= '0;
      start_q <= 1'b0;
      grant_q <= '0;
      indx_q  <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      pend_q  <= pend_d;
      rr_q    <= rr_d;
      sel_q   <= sel_d;
      start_q <= start_d;
      grant_q <= grant_d;
      indx_q  <= indx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    sel_d   = sel_q;
    case (state_q)
      StIdle: begin
        if (pend_q != 4'b0000) begin
          sel_d   = pick;
          state_d = StIssue;
        end
      end
      StIssue: begin
        timer_d = '0;
        state_d = StNote;
      end
      StNote: begin
        if (timer_q == NOTE_CYCLES - 25'd1) begin
          timer_d = '0;
          state_d = (GAP_CYCLES == 25'd0) ? StIdle : StGap;
        end else begin
          timer_d = timer_q + 25'd1;
        end
      end
      StGap: begin
        if (timer_q == GAP_CYCLES - 25'd1) begin
          timer_d = '0;
          state_d = StIdle;
        end else begin
          timer_d = timer_q + 25'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Issue outputs are registered: they are set on the IDLE->ISSUE transition.
  always_comb begin
    start_d = 1'b0;
    grant_d = '0;
    indx_d  = indx_q;
    rr_d    = rr_q;
    pend_d  = (clr ? 4'b0000 : (pend_q & ~grant_q)) | req;
    if (state_q == StIdle && pend_q != 4'b0000) begin
      start_d = 1'b1;
      grant_d = 4'b0001 << pick;
      indx_d  = pick;
    end
    if (state_q == StIssue) begin
      rr_d = sel_q + 2'd1;
    end
  end

  assign start      = start_q;
  assign grant      = grant_q;
  assign piezo_indx = indx_q;
  assign busy       = (state_q != StIdle);
  assign pend       = pend_q;

endmodule

// File: doc/piezo_sched.md
# piezo_sched

Request scheduler in front of the single-tone piezo driver. Up to four requesters post tone requests as single-cycle pulses. The block latches them, picks one at a time round-robin, and issues a one-cycle `start` with the matching `piezo_indx` to the driver. It then holds off further issues until the note and a silence gap have elapsed, so no note is restarted or truncated by a later request.

## Interface
- `NOTE_CYCLES`, default 25'h0800002: cycles spent in NOTE after each issue. Must be at least the driver's note length (0x800000 clocks plus 2 cycles of start/stop latency).
- `GAP_CYCLES`, default 25'h0100000: silent cycles after NOTE before the next issue. 0 is legal and skips GAP.
- `clk` in 1: system clock. All logic is on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in 4: per-requester request pulses. Bit i requests tone index i.
- `clr` in 1: synchronous flush of all pending requests.
- `start` out 1: one-cycle issue strobe to the driver.
- `piezo_indx` out 2: tone index to the driver. Valid while `start`=1 and held until the next issue.
- `grant` out 4: one-hot, asserted in the same cycle as `start`, marking the served requester.
- `busy` out 1: high when the state is not IDLE.
- `pend` out 4: current pending bits, for status.

## Operation
- Pending register `pend[3:0]`:
  - Each cycle: `pend <= (clr ? 0 : pend & ~grant) | req`.
  - `req` wins over both `clr` and `grant` in the same cycle.
  - A repeat `req` on a bit that is already pending merges into one request; there is no counting.
- Round-robin pointer `rr[1:0]` names the highest-priority requester.
  - Reset value is 0.
  - On a grant to i, `rr <= i+1` (mod 4).
  - Selection searches from `rr` upward with wrap-around and takes the first pending bit.
- State machine, 2-bit encoding:
  - IDLE: if `pend` != 0, latch the selected index into `sel` and go to ISSUE. Otherwise stay.
  - ISSUE (exactly 1 cycle): drive `start`=1, `piezo_indx`=`sel`, `grant`=1<<`sel`, clear the timer, go to NOTE.
  - NOTE: increment the timer. When timer == NOTE_CYCLES-1, clear the timer and go to GAP. If GAP_CYCLES == 0, go to IDLE instead.
  - GAP: increment the timer. When timer == GAP_CYCLES-1, go to IDLE.
- Timer:
  - 25-bit unsigned, wide enough for the parameter range.
  - Compare is equality against parameter-1; the timer never wraps.
- `clr` affects only `pend`. A note already issued completes, including its NOTE and GAP; the driver cannot be stopped.
- `sel` is latched in IDLE, so requests or `clr` arriving during ISSUE/NOTE/GAP never change the tone being played.
- Reset values:
  - `state` = IDLE, timer = 0, `pend` = 0, `rr` = 0, `sel` = 0.
  - Outputs: `start` = 0, `grant` = 0, `piezo_indx` = 0, `busy` = 0.
- Reset asserted mid-note: everything returns to reset values immediately and all pending requests are lost.

## Timing
- `start`, `grant` and `piezo_indx` are registered outputs; the driver samples `start` on the following edge.
- Latency from an idle block with empty `pend`:
  - `req` high in cycle N.
  - `pend` set in N+1, where IDLE selects it.
  - `start` high in N+2.
- Issue spacing under continuous demand: 1 (ISSUE) + NOTE_CYCLES + GAP_CYCLES + 1 (IDLE) cycles between `start` pulses.
- `busy` rises in the ISSUE cycle and falls in the cycle the block returns to IDLE.
- `start` is never high in two consecutive cycles. `grant` is always one-hot or zero.

## Test plan
Use NOTE_CYCLES=8 and GAP_CYCLES=4 unless stated otherwise.

1. Reset check: assert `rst_n`=0 mid-NOTE.
   - Immediately: `busy`=0, `pend`=0, `start`=0, `piezo_indx`=0.
   - After release, no `start` occurs without a new `req`.
2. Single request: `req`=4'b0100 in cycle 10.
   - `pend`=4'b0100 at cycle 11.
   - `start`=1, `piezo_indx`=2, `grant`=4'b0100 at cycle 12.
   - `busy` falls at cycle 25.
3. Round-robin: `req`=4'b1111 in one cycle.
   - Starts occur with indices 0, 1, 2, 3 in that order, spaced exactly 14 cycles apart.
   - `pend` empties after the fourth grant.
4. Pointer wrap: grant index 3, then pulse `req`=4'b0011.
   - Next issue is index 0, then index 1.
5. Simultaneous events:
   - `req`[1] in the same cycle as `grant`=4'b0010: bit 1 stays pending and is served again.
   - `clr` together with `req`=4'b0001 while `pend`=4'b1000: result is `pend`=4'b0001.
6. GAP_CYCLES=0 with back-to-back demand: `start` pulses are spaced 10 cycles apart and GAP is never entered.
